acc_synth_pipe: RTL and testbench

ACC_SYNTH_PIPE -- requirements
Module: acc_synth_pipe

---
 rtl/acc_synth_pkg.sv | 21 ++
 rtl/acc_synth_fifo.sv | 53 +++++
 rtl/acc_synth_pipe.sv | 142 ++++++++++++++
 tb/tb_acc_synth_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_synth_pkg.sv
// acc_synth_pipe shared types: FSM states, latched job config, counter widths.
// Used by the top; the FIFO stays type-agnostic.
package acc_synth_pkg;

  localparam int CNT_W  = 16;
  localparam int WAIT_W = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONSUME = 2'd1,
    WAIT    = 2'd2,
    PRODUCE = 2'd3
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0]  ser;
    logic [CNT_W-1:0]  des;
    logic [WAIT_W-1:0] wt;
  } job_cfg_t;

endpackage

// File: rtl/acc_synth_fifo.sv
// Output FIFO for acc_synth_pipe: registered head, full/empty flags,
// push accepted while full if a pop happens in the same cycle.
module acc_synth_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr, rd;

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o  = mem[rptr_q];

  assign wr = push_i && (!full_o || pop_i);
  assign rd = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (wr && !rd) cnt_d = cnt_q + 1'b1;
    if (rd && !wr) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= din_i;
  end

endmodule

// File: rtl/acc_synth_pipe.sv
// Consume/wait/produce job engine with queued output beats.
// ACC_SYNTH_CHECKSUM_EN: acc is XOR of the job's beats, else the last beat.
module acc_synth_pipe
  import acc_synth_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int OUT_DEPTH = 4,
  parameter int JOB_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cfg_ser_ratio,
  input  logic [CNT_W-1:0]  cfg_des_ratio,
  input  logic [WAIT_W-1:0] cfg_wait_cycles,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [JOB_W-1:0]  jobs_done
);

  state_t              state_q, state_d;
  job_cfg_t            job_q, job_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    beat_q, beat_d, beat_nx;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [JOB_W-1:0]    jobs_q, jobs_d;

  logic                push, pop, full, empty;
  logic                zero_done, in_hs;
  logic [DATA_W:0]     fifo_din, fifo_dout;

  assign beat_nx   = beat_q + 1'b1;
  assign in_ready  = (state_q == CONSUME) && (job_q.ser != '0);
  assign in_hs     = in_valid && in_ready;
  assign out_valid = !empty;
  assign out_data  = fifo_dout[DATA_W-1:0];
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q != IDLE) || !empty;
  assign jobs_done = jobs_q;

  // beat_q doubles as the output index k while producing
  assign fifo_din = {beat_nx == job_q.des,
                     acc_q ^ DATA_W'(beat_q)};

  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    acc_d     = acc_q;
    beat_d    = beat_q;
    wcnt_d    = wcnt_q;
    push      = 1'b0;
    zero_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          job_d   = '{ser: cfg_ser_ratio,
                      des: cfg_des_ratio,
                      wt:  cfg_wait_cycles};
          acc_d   = '0;
          beat_d  = '0;
          wcnt_d  = '0;
          state_d = CONSUME;
        end
      end
      CONSUME: begin
        if (job_q.ser == '0) begin
          state_d = WAIT;
        end else if (in_hs) begin
          beat_d = beat_nx;
`ifdef ACC_SYNTH_CHECKSUM_EN
          acc_d = acc_q ^ in_data;
`else
          acc_d = in_data;
`endif
          if (beat_nx == job_q.ser) begin
            beat_d  = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (job_q.wt == '0 || wcnt_d == job_q.wt)
          state_d = PRODUCE;
      end
      PRODUCE: begin
        if (job_q.des == '0) begin
          zero_done = 1'b1;
          state_d   = IDLE;
        end else if (!full || pop) begin
          push   = 1'b1;
          beat_d = beat_nx;
          if (beat_nx == job_q.des) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    jobs_d = jobs_q
           + JOB_W'(pop && fifo_dout[DATA_W])
           + JOB_W'(zero_done);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      job_q   <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      wcnt_q  <= '0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
      jobs_q  <= jobs_d;
    end
  end

  acc_synth_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_acc_synth_pipe.sv
// Directed bench for acc_synth_pipe: latency, backpressure, zero-ratio,
// config latching and mid-job reset, with hand-computed expectations.
module tb_acc_synth_pipe;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   cfg_ser, cfg_des;
  logic [13:0]   cfg_wait;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic [15:0]   jobs_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] got [$];

`ifdef ACC_SYNTH_CHECKSUM_EN
  localparam logic [63:0] T1_ACC = 64'hFF;
  localparam logic [63:0] T4_ACC = 64'h33;
`else
  localparam logic [63:0] T1_ACC = 64'hF0;
  localparam logic [63:0] T4_ACC = 64'h22;
`endif

  acc_synth_pipe dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_ser_ratio   (cfg_ser),
    .cfg_des_ratio   (cfg_des),
    .cfg_wait_cycles (cfg_wait),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .busy            (busy),
    .jobs_done       (jobs_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (out_valid && out_ready) got.push_back(out_data);

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] gq(int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(int s, int d, int w);
    cfg_ser  = 16'(s);
    cfg_des  = 16'(d);
    cfg_wait = 14'(w);
  endtask

  task automatic send(logic [63:0] d);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_tmo", 64'(in_ready), 64'd1);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic lat(output int k);
    for (k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    step(1);
  endtask

  int base, k, n;
  bit saw;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    cfg(0, 0, 0);
    @(negedge clk);
    chk("rst_rdy",  64'(in_ready),  64'd0);
    chk("rst_vld",  64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy),      64'd0);
    chk("rst_jobs", 64'(jobs_done), 64'd0);
    step(1);
    rst = 1'b0;
    step(2);

    // ser=2 des=3 wait=4
    out_ready = 1'b1;
    cfg(2, 3, 4);
    base = got.size();
    send(64'h0F);
    send(64'hF0);
    lat(k);
    chk("t1_lat", 64'(k), 64'd6);
    step(10);
    chk("t1_n", 64'(got.size() - base), 64'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t1_b%0d", i), gq(base + i),
          T1_ACC ^ 64'(i));
    chk("t1_jobs", 64'(jobs_done), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);

    // all-zero job: three busy cycles, no handshakes
    cfg(0, 0, 0);
    base = got.size();
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    n = 0;
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) saw = 1;
      if (!busy) break;
      n++;
    end
    chk("z_cyc",  64'(n),   64'd3);
    chk("z_rdy",  64'(saw), 64'd0);
    chk("z_jobs", 64'(jobs_done), 64'd2);
    chk("z_n", 64'(got.size() - base), 64'd0);
    step(1);

    // backpressure: des=8 into a 4-deep FIFO
    out_ready = 1'b0;
    cfg(1, 8, 0);
    base = got.size();
    send(64'hA0);
    step(20);
    chk("bp_cnt",  64'(dut.u_fifo.cnt_q), 64'd4);
    chk("bp_busy", 64'(busy),      64'd1);
    chk("bp_vld",  64'(out_valid), 64'd1);
    chk("bp_n0", 64'(got.size() - base), 64'd0);
    out_ready = 1'b1;
    step(20);
    chk("bp_n", 64'(got.size() - base), 64'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("bp_b%0d", i), gq(base + i),
          64'hA0 ^ 64'(i));
    chk("bp_jobs", 64'(jobs_done), 64'd3);

    // cfg change mid-CONSUME
    cfg(2, 1, 1);
    base = got.size();
    send(64'h11);
    cfg(1, 2, 0);
    send(64'h22);
    step(15);
    send(64'h40);
    step(15);
    chk("cf_n", 64'(got.size() - base), 64'd3);
    chk("cf_b0", gq(base),     T4_ACC);
    chk("cf_b1", gq(base + 1), 64'h40);
    chk("cf_b2", gq(base + 2), 64'h41);
    chk("cf_jobs", 64'(jobs_done), 64'd5);

    // reset during beat 1 of 4
    cfg(4, 1, 0);
    base = got.size();
    send(64'h1);
    step(1);
    rst = 1'b1;
    #1;
    chk("mr_vld",  64'(out_valid), 64'd0);
    chk("mr_busy", 64'(busy),      64'd0);
    chk("mr_jobs", 64'(jobs_done), 64'd0);
    chk("mr_rdy",  64'(in_ready),  64'd0);
    step(2);
    rst = 1'b0;
    step(5);
    chk("mr_n0", 64'(got.size() - base), 64'd0);
    cfg(1, 1, 1);
    send(64'h5);
    lat(k);
    chk("mr_lat", 64'(k), 64'd3);
    step(5);
    chk("mr_n",    64'(got.size() - base), 64'd1);
    chk("mr_b0",   gq(base), 64'h5);
    chk("mr_jobs1", 64'(jobs_done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
